// File: rtl/rv32i_dmem_lsu.sv
// RV32I data-memory load/store unit driving a byte-wide synchronous RAM.
// Multi-byte accesses are serialised one byte per cycle, little-endian.
module rv32i_dmem_lsu #(
  parameter int unsigned AWIDTH = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic [7:0]        ram_data,
  output logic              ram_wren,
  output logic [AWIDTH-1:0] ram_address,
  input  logic [7:0]        ram_q
);

  typedef enum logic [1:0] {StIdle, StAccess, StLast} state_e;

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [2:0]          funct3_q;
  logic [AWIDTH-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         buf_q, buf_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;

  logic                accept;
  logic                req_err;
  logic [1:0]          last_idx;
  logic [1:0]          prev_idx;
  logic [31:0]         assembled;
  logic                unused_addr;

  // Upper address bits are ignored on purpose: the RAM aliases across them.
  assign unused_addr = ^req_addr[31:AWIDTH];

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid && req_ready;

  // Classify the incoming request as illegal before any RAM access.
  always_comb begin
    req_err = 1'b0;
    unique case (req_funct3)
      3'b011, 3'b110, 3'b111: req_err = 1'b1;
      default:                req_err = 1'b0;
    endcase
    if (req_we && req_funct3[2]) req_err = 1'b1;
    if ((req_funct3[1:0] == 2'b01) && req_addr[0]) req_err = 1'b1;
    if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) req_err = 1'b1;
  end

  // Index of the final byte of the registered access (N-1).
  always_comb begin
    unique case (funct3_q[1:0])
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  // RAM q lags the address by one cycle, so the byte arriving now belongs to cnt-1.
  assign prev_idx = cnt_q - 2'd1;

  // Merge the final byte straight from ram_q into the captured bytes.
  always_comb begin
    assembled = buf_q;
    assembled[8*last_idx +: 8] = ram_q;
  end

  // Next-state, byte capture and response generation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = StAccess;
            cnt_d   = 2'd0;
            buf_d   = 32'h0;
          end
        end
      end
      StAccess: begin
        if (cnt_q != 2'd0) buf_d[8*prev_idx +: 8] = ram_q;
        if (cnt_q == last_idx) begin
          if (we_q) begin
            state_d     = StIdle;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = StLast;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StLast: begin
        state_d     = StIdle;
        rsp_valid_d = 1'b1;
        unique case (funct3_q)
          3'b000:  rsp_rdata_d = {{24{assembled[7]}}, assembled[7:0]};
          3'b001:  rsp_rdata_d = {{16{assembled[15]}}, assembled[15:0]};
          3'b100:  rsp_rdata_d = {24'h0, assembled[7:0]};
          3'b101:  rsp_rdata_d = {16'h0, assembled[15:0]};
          default: rsp_rdata_d = assembled;
        endcase
      end
      default: state_d = StIdle;
    endcase
  end

  // RAM port: only active during ACCESS, otherwise held at zero.
  always_comb begin
    ram_wren    = 1'b0;
    ram_data    = 8'h0;
    ram_address = '0;
    if (state_q == StAccess) begin
      ram_address = addr_q + AWIDTH'(cnt_q);
      ram_wren    = we_q;
      if (we_q) ram_data = wdata_q[8*cnt_q +: 8];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  // State and request registers; request fields latch only on acceptance.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      buf_q       <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr[AWIDTH-1:0];
        wdata_q  <= req_wdata;
      end
    end
  end

endmodule

// File: doc/rv32i_dmem_lsu.md
RV32I_DMEM_LSU -- requirements
Module: rv32i_dmem_lsu

Interface
REQ-001 The block SHALL have parameter AWIDTH, default 11: byte-RAM address width.
REQ-002 The block SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have port req_valid, input, 1: core memory request present.
REQ-005 The block SHALL have port req_ready, output, 1: block can accept a request this cycle.
REQ-006 The block SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-007 The block SHALL have port req_funct3, input, 3: RV32I width and sign code.
REQ-008 The block SHALL have port req_addr, input, 32: byte address.
REQ-009 The block SHALL have port req_wdata, input, 32: store data, byte 0 = bits 7:0.
REQ-010 The block SHALL have port rsp_valid, output, 1: one-cycle completion pulse.
REQ-011 The block SHALL have port rsp_err, output, 1: request rejected, valid with rsp_valid.
REQ-012 The block SHALL have port rsp_rdata, output, 32: extended load result, valid with rsp_valid.
REQ-013 The block SHALL have ports ram_data (output, 8), ram_wren (output, 1), ram_address (output, AWIDTH) and ram_q (input, 8), connecting to a byte RAM whose q is registered one cycle after the address.

Function
REQ-014 The block SHALL accept a request at cycle T when req_valid and req_ready are both 1; req_ready SHALL be 1 only in IDLE.
REQ-015 The block SHALL use states IDLE, ACCESS, LAST (loads only) and back to IDLE; byte count N is 1 for funct3 x00, 2 for x01 and 4 for 010.
REQ-016 The block SHALL treat as errors: funct3 011/110/111; store with funct3[2]=1; halfword with addr[0]=1; word with addr[1:0]!=0.
REQ-017 On an error request the block SHALL perform no RAM access and SHALL pulse rsp_valid=1, rsp_err=1, rsp_rdata=0 in cycle T+1.
REQ-018 In ACCESS cycles T+1+k (k=0..N-1) the block SHALL drive ram_address = req_addr[AWIDTH-1:0]+k; little-endian; bits 31:AWIDTH ignored, so addresses alias.
REQ-019 Stores SHALL drive ram_wren=1 and ram_data = req_wdata byte k in cycle T+1+k; rsp_valid SHALL pulse in cycle T+N+1 with rsp_rdata=0.
REQ-020 Loads SHALL keep ram_wren=0 and SHALL capture ram_q in cycle T+2+k as byte k.
REQ-021 Loads SHALL pulse rsp_valid in cycle T+N+2.
REQ-022 rsp_rdata SHALL be sign-extended for LB (000) and LH (001), zero-extended for LBU (100) and LHU (101), and the full word for LW (010).
REQ-023 The block SHALL register req_we, req_funct3, req_addr and req_wdata at acceptance; input changes during ACCESS or LAST SHALL have no effect.
REQ-024 The rsp_valid cycle SHALL be an IDLE cycle with req_ready=1, so a back-to-back request is accepted in that same cycle.
REQ-025 In IDLE, ram_wren, ram_data and ram_address SHALL be 0.
REQ-026 Outside its rsp_valid cycle, rsp_err and rsp_rdata SHALL hold 0.
REQ-027 req_valid while req_ready=0 SHALL be ignored; the requester holds the request until it is accepted.

Reset
REQ-028 When reset=1 at a rising edge, the block SHALL enter IDLE, with req_ready=1 and all other outputs 0 from the next cycle.
REQ-029 Reset SHALL take priority over a simultaneous req_valid.
REQ-030 Reset during ACCESS SHALL abort the operation with no rsp_valid; RAM bytes already written stay written, and ram_wren SHALL be 0 in the cycle after the reset edge.

Verification
REQ-031 SW addr 0x100, wdata 0xA1B2C3D4 -> cycles T+1..T+4: ram_wren=1, addresses 0x100..0x103, data D4,C3,B2,A1; rsp_valid at T+5, rsp_err=0.
REQ-032 After REQ-031, LB 0x103 -> rsp_rdata 0xFFFFFFA1 at T+3; LBU 0x103 -> 0x000000A1; LH 0x102 -> 0xFFFFA1B2 at T+4; LW 0x100 -> 0xA1B2C3D4 at T+6.
REQ-033 LW addr 0x102, LH 0x101, funct3 011, and SB with funct3 100 -> each gives rsp_valid=1, rsp_err=1 at T+1 with ram_wren never asserted.
REQ-034 Back-to-back SB 0x7FF data 0x5A, then LBU 0x7FF accepted in the SB rsp_valid cycle -> load returns 0x0000005A; SB 0x800 (aliasing) overwrites address 0x000.
REQ-035 Assert reset in cycle T+2 of a SW to 0x200 -> no rsp_valid; bytes 0x200 and 0x201 written, 0x202 and 0x203 unchanged; req_ready=1 after reset.
